// File: rtl/wb_arb_pkg.sv
// Shared types and constants for the two-master Wishbone arbiter.
package wb_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } arb_state_e;

  localparam int unsigned           OUTST_W   = 4;
  localparam logic [OUTST_W-1:0]    MAX_OUTST = 4'd15;

endpackage

// File: rtl/wb_arb_timeout.sv
// Watchdog counter for the arbiter: counts while run_i is high, clears on
// restart_i or when idle, and flags terminal count after LIMIT running clocks.
module wb_arb_timeout #(
  parameter int unsigned LIMIT = 1023
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic run_i,
  input  logic restart_i,
  output logic tc_o
);

  localparam int unsigned CW = $clog2(LIMIT + 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Restart takes priority so a response arriving on the limit cycle wins.
  assign tc_o = run_i && !restart_i && (cnt_q == CW'(LIMIT - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (restart_i || !run_i) begin
      cnt_d = '0;
    end else if (!tc_o) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/wb_arbiter2.sv
// Two-master pipelined Wishbone arbiter, round-robin per bus cycle.
// Optional hung-cycle watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wb_arbiter2
  import wb_arb_pkg::*;
#(
  parameter  int unsigned AW             = 32,
  parameter  int unsigned DW             = 32,
  parameter  int unsigned TIMEOUT_CYCLES = 1023,
  localparam int unsigned SW             = DW / 8
) (
  input  logic              clk,
  input  logic              i_resetn,
  input  logic [1:0]        i_m2s_cyc,
  input  logic [1:0]        i_m2s_stb,
  input  logic [1:0]        i_m2s_we,
  input  logic [2*AW-1:0]   i_m2s_addr,
  input  logic [2*DW-1:0]   i_m2s_data,
  input  logic [2*SW-1:0]   i_m2s_sel,
  output logic [DW-1:0]     o_s2m_data,
  output logic [1:0]        o_s2m_ack,
  output logic [1:0]        o_s2m_stall,
  output logic [1:0]        o_s2m_err,
  output logic              o_wb_m2s_cyc,
  output logic              o_wb_m2s_stb,
  output logic              o_wb_m2s_we,
  output logic [AW-1:0]     o_wb_m2s_addr,
  output logic [DW-1:0]     o_wb_m2s_data,
  output logic [SW-1:0]     o_wb_m2s_sel,
  input  logic [DW-1:0]     i_wb_s2m_data,
  input  logic              i_wb_s2m_ack,
  input  logic              i_wb_s2m_stall,
  input  logic              i_wb_s2m_err,
  output logic [1:0]        o_grant
);

  arb_state_e         state_q, state_d;
  logic               last_q, last_d;
  logic [OUTST_W-1:0] cnt_q, cnt_d;

  logic          owning, own;
  logic          m_cyc, m_stb, m_we;
  logic [AW-1:0] m_addr;
  logic [DW-1:0] m_data;
  logic [SW-1:0] m_sel;
  logic          full, pre_stb, accept, resp, tmo;

  assign owning = (state_q != IDLE);
  assign own    = (state_q == OWN1);

  assign m_cyc  = owning & i_m2s_cyc[own];
  assign m_stb  = i_m2s_stb[own];
  assign m_we   = i_m2s_we[own];
  assign m_addr = own ? i_m2s_addr[AW +: AW] : i_m2s_addr[0 +: AW];
  assign m_data = own ? i_m2s_data[DW +: DW] : i_m2s_data[0 +: DW];
  assign m_sel  = own ? i_m2s_sel[SW +: SW]  : i_m2s_sel[0 +: SW];

  assign full    = (cnt_q == MAX_OUTST);
  // pre_stb excludes the watchdog so its restart path stays loop-free.
  assign pre_stb = m_cyc & m_stb & ~full;
  assign resp    = i_wb_s2m_ack | i_wb_s2m_err;

  assign o_wb_m2s_cyc  = m_cyc & ~tmo;
  assign o_wb_m2s_stb  = pre_stb & ~tmo;
  assign o_wb_m2s_we   = m_cyc & m_we;
  assign o_wb_m2s_addr = owning ? m_addr : '0;
  assign o_wb_m2s_data = owning ? m_data : '0;
  assign o_wb_m2s_sel  = owning ? m_sel  : '0;
  assign accept        = o_wb_m2s_stb & ~i_wb_s2m_stall;

  assign o_s2m_data = i_wb_s2m_data;
  assign o_grant    = {state_q == OWN1, state_q == OWN0};

  always_comb begin
    o_s2m_ack   = '0;
    o_s2m_err   = '0;
    o_s2m_stall = '1;
    if (owning) begin
      o_s2m_ack[own]   = m_cyc & i_wb_s2m_ack;
      o_s2m_err[own]   = (m_cyc & i_wb_s2m_err) | tmo;
      o_s2m_stall[own] = i_wb_s2m_stall | full;
    end
  end

  // Dropping cyc aborts the cycle, so outstanding transfers are forgotten.
  always_comb begin
    cnt_d = cnt_q;
    if (!m_cyc || tmo) begin
      cnt_d = '0;
    end else if (accept && !resp) begin
      cnt_d = cnt_q + 1'b1;
    end else if (!accept && resp && (cnt_q != '0)) begin
      cnt_d = cnt_q - 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    case (state_q)
      IDLE: begin
        case (i_m2s_cyc)
          2'b01:   state_d = OWN0;
          2'b10:   state_d = OWN1;
          2'b11:   state_d = last_q ? OWN0 : OWN1;
          default: state_d = IDLE;
        endcase
        if (state_d == OWN0) last_d = 1'b0;
        if (state_d == OWN1) last_d = 1'b1;
      end
      OWN0, OWN1: begin
        if (!m_cyc || tmo) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q <= IDLE;
      last_q  <= 1'b1;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
    end
  end

`ifdef WB_ARB_TIMEOUT_EN
  logic wd_run, wd_restart;

  assign wd_run     = m_cyc & ((cnt_q != '0) | (m_stb & (i_wb_s2m_stall | full)));
  assign wd_restart = (pre_stb & ~i_wb_s2m_stall) | resp;

  wb_arb_timeout #(
    .LIMIT (TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i     (clk),
    .rst_ni    (i_resetn),
    .run_i     (wd_run),
    .restart_i (wd_restart),
    .tc_o      (tmo)
  );
`else
  // No watchdog in this build; TIMEOUT_CYCLES has no effect.
  assign tmo = (TIMEOUT_CYCLES == 0) & 1'b0;
`endif

endmodule
